// File: rtl/adc_if_pkg.sv
// ---------------------------------------------------------------------------
// adc_if_pkg
//   Shared definitions for the ADC clock supervisor.
//   - FSM state codes (also exported on the status port)
//   - Default legal edge-count range, derived from the nominal clocking:
//       sys clk 100 MHz, ADC clk 150 MHz, toggle divider 8, gate 1024 clk.
//       Both toggle edges count, so nominal = 1024*2*150/(8*2*100) = 192.
//       Tolerance is +/-4%, rounded outward to whole counts (+/-8).
// ---------------------------------------------------------------------------
package adc_if_pkg;

  localparam logic [1:0] ST_MEASURE = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  typedef enum logic [1:0] {
    MEASURE = ST_MEASURE,
    SETTLE  = ST_SETTLE,
    HOLD    = ST_HOLD,
    RUN     = ST_RUN
  } adc_state_e;

  localparam int SYS_MHZ  = 100;
  localparam int ADC_MHZ  = 150;
  localparam int TOG_DIV  = 8;
  localparam int DEF_GATE = 1024;
  localparam int TOL_PCT  = 4;

  // Edges per gate window at nominal frequencies.
  localparam int NOM_CNT = (DEF_GATE * 2 * ADC_MHZ) / (TOG_DIV * 2 * SYS_MHZ);

  // Tolerance in counts, rounded up so the legal window never shrinks.
  function automatic int tol_counts(input int nom, input int pct);
    return (nom * pct + 99) / 100;
  endfunction

  localparam int DEF_CNT_MIN = NOM_CNT - tol_counts(NOM_CNT, TOL_PCT);  // 184
  localparam int DEF_CNT_MAX = NOM_CNT + tol_counts(NOM_CNT, TOL_PCT);  // 200

endpackage

// File: rtl/adc_tog_sync.sv
// ---------------------------------------------------------------------------
// adc_tog_sync
//   Brings the ADC-domain toggle bit into the system clock domain and turns
//   each transition (rising or falling) into a single-cycle pulse.
//   Two flops resolve metastability; the third flop holds the previous
//   synchronized value so the XOR sees only settled data.
//   Pin-to-pulse latency is 2-3 clk depending on sampling phase.
// Ports
//   clk     in   system clock
//   rst     in   async active-high reset
//   tog     in   ADC-domain toggle bit (asynchronous)
//   edge_p  out  1-cycle pulse per toggle transition
// ---------------------------------------------------------------------------
module adc_tog_sync (
  input  logic clk,
  input  logic rst,
  input  logic tog,
  output logic edge_p
);

  // [0]=first sync flop, [1]=second sync flop, [2]=delayed copy
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], tog};
  end

  assign edge_p = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/adc_clk_supervisor.sv
// ---------------------------------------------------------------------------
// adc_clk_supervisor
//   Measures the ADC sample clock by counting toggle edges over fixed gate
//   windows of the system clock, and sequences the ADC interface reset:
//     MEASURE -> (good window) -> SETTLE -> (GOOD_WINDOWS in a row) -> HOLD
//     -> (RST_HOLD clk) -> RUN.  A bad window in RUN sets the sticky lost
//     flag and drops back to MEASURE.
// Ports
//   clk           in   system clock
//   rst           in   async active-high reset
//   adc_clk_tog   in   ADC-domain toggle bit (asynchronous)
//   restart       in   1-cycle pulse: restart acquisition from MEASURE
//   clr_lost      in   1-cycle pulse: clear adc_clk_lost
//   adc_rst       out  ADC interface reset, low only in RUN
//   adc_clk_ok    out  high only in RUN
//   adc_clk_lost  out  sticky, set by a bad window while in RUN
//   adc_cnt       out  edge count of the last completed window
//   cnt_valid     out  1-cycle pulse when adc_cnt updates
//   state         out  FSM state code
// ---------------------------------------------------------------------------
module adc_clk_supervisor
  import adc_if_pkg::*;
#(
  parameter int GATE_CYCLES  = 1024,
  parameter int CNT_W        = 16,
  parameter int CNT_MIN      = DEF_CNT_MIN,
  parameter int CNT_MAX      = DEF_CNT_MAX,
  parameter int GOOD_WINDOWS = 4,
  parameter int RST_HOLD     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adc_clk_tog,
  input  logic             restart,
  input  logic             clr_lost,
  output logic             adc_rst,
  output logic             adc_clk_ok,
  output logic             adc_clk_lost,
  output logic [CNT_W-1:0] adc_cnt,
  output logic             cnt_valid,
  output logic [1:0]       state
);

  localparam int GW   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int GC_W = $clog2(GOOD_WINDOWS + 1);
  localparam int HC_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(CNT_MIN);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(CNT_MAX);
  localparam logic [GC_W-1:0]  GOOD_LAST = GC_W'(GOOD_WINDOWS - 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(RST_HOLD - 1);

  logic             edge_p;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] cnt_fin;
  logic             win_end;
  logic             win_good;

  adc_state_e       state_q, state_nx;
  logic [GC_W-1:0]  good_cnt, good_nx;
  logic [HC_W-1:0]  hold_cnt;
  logic             lost_set;

  // -------------------------------------------------------------------------
  // Toggle synchronizer
  // -------------------------------------------------------------------------
  adc_tog_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .tog    (adc_clk_tog),
    .edge_p (edge_p)
  );

  // -------------------------------------------------------------------------
  // Gate window and edge count
  //   edge_cnt holds edges seen in cycles before the current one; cnt_fin
  //   adds the current cycle's edge, so an edge in the last gate cycle lands
  //   in the window that is closing, and the counter restarts clean.
  // -------------------------------------------------------------------------
  always_comb begin
    win_end  = (gate_cnt == GATE_LAST);
    cnt_fin  = (edge_p && (edge_cnt != CNT_SAT)) ? edge_cnt + 1'b1 : edge_cnt;
    win_good = (cnt_fin >= MIN_C) && (cnt_fin <= MAX_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      adc_cnt   <= '0;
      cnt_valid <= 1'b0;
    end else if (restart) begin
      // Partial window is discarded; adc_cnt keeps the last full result.
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= win_end;
      if (win_end) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        adc_cnt  <= cnt_fin;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= cnt_fin;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state decode. Window decisions use cnt_fin, i.e. the value adc_cnt
  // takes at the same edge, so status and count stay consistent.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state_q;
    good_nx  = good_cnt;
    lost_set = 1'b0;
    if (restart) begin
      state_nx = MEASURE;
      good_nx  = '0;
    end else begin
      unique case (state_q)
        MEASURE: begin
          if (win_end && win_good) begin
            good_nx  = GC_W'(1);
            state_nx = (GOOD_WINDOWS == 1) ? HOLD : SETTLE;
          end
        end
        SETTLE: begin
          if (win_end) begin
            if (win_good) begin
              good_nx = good_cnt + 1'b1;
              if (good_cnt == GOOD_LAST) state_nx = HOLD;
            end else begin
              good_nx  = '0;
              state_nx = MEASURE;
            end
          end
        end
        HOLD: begin
          // Window results are ignored while the ADC reset is being held.
          if (hold_cnt == HOLD_LAST) state_nx = RUN;
        end
        RUN: begin
          if (win_end && !win_good) begin
            lost_set = 1'b1;
            good_nx  = '0;
            state_nx = MEASURE;
          end
        end
        default: begin
          state_nx = MEASURE;
          good_nx  = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State register and registered outputs. adc_rst/adc_clk_ok decode the
  // next state so they change in the same cycle the state does.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MEASURE;
      good_cnt     <= '0;
      hold_cnt     <= '0;
      adc_rst      <= 1'b1;
      adc_clk_ok   <= 1'b0;
      adc_clk_lost <= 1'b0;
    end else begin
      state_q    <= state_nx;
      good_cnt   <= good_nx;
      hold_cnt   <= (state_q == HOLD && state_nx == HOLD) ? hold_cnt + 1'b1 : '0;
      adc_rst    <= (state_nx != RUN);
      adc_clk_ok <= (state_nx == RUN);
      // A set event beats a simultaneous clear.
      if (lost_set)      adc_clk_lost <= 1'b1;
      else if (clr_lost) adc_clk_lost <= 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_adc_clk_supervisor.sv
module tb_adc_clk_supervisor;

  localparam int GATE = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tog = 1'b0;
  logic        tog2 = 1'b0;
  logic        restart = 1'b0;
  logic        clr_lost = 1'b0;

  logic        adc_rst, adc_clk_ok, adc_clk_lost, cnt_valid;
  logic [15:0] adc_cnt;
  logic [1:0]  state;

  logic        s_rst, s_ok, s_lost, s_valid;
  logic [3:0]  s_cnt;
  logic [1:0]  s_state;

  int checks = 0;
  int errors = 0;

  // Toggle generator control: period in clk (0 = stopped), plus one-shot flips.
  int tog_per = 0;
  int flip_cnt = 0;
  int flip_seen = 0;
  int tcnt = 0;

  typedef struct { int lo; int hi; } exp_t;
  exp_t sb[$];
  exp_t sb_sat[$];

  always #5 clk = ~clk;

  adc_clk_supervisor #(
    .GATE_CYCLES(GATE), .CNT_W(16), .CNT_MIN(18), .CNT_MAX(22),
    .GOOD_WINDOWS(4), .RST_HOLD(16)
  ) u_dut (
    .clk(clk), .rst(rst), .adc_clk_tog(tog), .restart(restart), .clr_lost(clr_lost),
    .adc_rst(adc_rst), .adc_clk_ok(adc_clk_ok), .adc_clk_lost(adc_clk_lost),
    .adc_cnt(adc_cnt), .cnt_valid(cnt_valid), .state(state)
  );

  // Narrow counter instance, toggled every clk, to exercise saturation.
  adc_clk_supervisor #(
    .GATE_CYCLES(GATE), .CNT_W(4), .CNT_MIN(10), .CNT_MAX(14),
    .GOOD_WINDOWS(4), .RST_HOLD(16)
  ) u_sat (
    .clk(clk), .rst(rst), .adc_clk_tog(tog2), .restart(1'b0), .clr_lost(1'b0),
    .adc_rst(s_rst), .adc_clk_ok(s_ok), .adc_clk_lost(s_lost),
    .adc_cnt(s_cnt), .cnt_valid(s_valid), .state(s_state)
  );

  task automatic chk(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d at %0t", nm, act, lo, hi, $time);
    end
  endtask

  // Single writer of tog/tog2, driven on the falling edge.
  initial forever begin
    @(negedge clk);
    tog2 = ~tog2;
    if (flip_cnt != flip_seen) begin
      flip_seen = flip_cnt;
      tog = ~tog;
      tcnt = 0;
    end else if (tog_per == 0) begin
      tcnt = 0;
    end else if (tcnt >= tog_per - 1) begin
      tcnt = 0;
      tog = ~tog;
    end else begin
      tcnt++;
    end
  end

  // Monitors: compare every cnt_valid that has an expectation queued.
  always @(negedge clk) begin
    exp_t e;
    if (cnt_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("adc_cnt", int'(adc_cnt), e.lo, e.hi);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (s_valid && sb_sat.size() > 0) begin
      e = sb_sat.pop_front();
      chk("sat_cnt", int'(s_cnt), e.lo, e.hi);
    end
  end

  // Returns on the falling edge of the cycle where cnt_valid is high
  // (gate counter == 0 of the new window).
  task automatic wait_win();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cnt_valid && n < 2 * GATE + 50);
    chk("window_end_seen", int'(cnt_valid), 1, 1);
  endtask

  // Called right after wait_win: set toggle period, expect this window's count.
  task automatic expect_win(input int per, input int lo, input int hi);
    exp_t e;
    #2;
    tog_per = per;
    e.lo = lo;
    e.hi = hi;
    sb.push_back(e);
    wait_win();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n;
  int pat_per [8] = '{5, 5, 5, 3, 5, 5, 5, 5};
  int pat_lo  [8] = '{19, 20, 20, 32, 19, 20, 20, 20};
  int pat_hi  [8] = '{21, 20, 20, 36, 21, 20, 20, 20};
  int pat_st  [8] = '{1, 1, 1, 0, 1, 1, 1, 2};

  initial begin
    exp_t e;
    // ---- reset values
    repeat (2) @(negedge clk);
    chk("rst_adc_rst", int'(adc_rst), 1, 1);
    chk("rst_clk_ok", int'(adc_clk_ok), 0, 0);
    chk("rst_lost", int'(adc_clk_lost), 0, 0);
    chk("rst_cnt", int'(adc_cnt), 0, 0);
    chk("rst_valid", int'(cnt_valid), 0, 0);
    chk("rst_state", int'(state), 0, 0);

    // ---- 1: toggle every 5 clk, lock and release
    rst = 1'b0;
    #2;
    tog_per = 5;
    e.lo = 18; e.hi = 20; sb.push_back(e);  // first window: start-up phase
    e.lo = 15; e.hi = 15; sb_sat.push_back(e); sb_sat.push_back(e);
    wait_win();
    chk("t1_state_settle", int'(state), 1, 1);
    for (int i = 0; i < 3; i++) begin
      expect_win(5, 20, 20);
      chk("t1_state", int'(state), (i < 2) ? 1 : 2, (i < 2) ? 1 : 2);
      chk("t1_adc_rst_held", int'(adc_rst), 1, 1);
    end
    n = 0;
    while (adc_rst && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t1_release_latency", n, 16, 17);
    chk("t1_clk_ok", int'(adc_clk_ok), 1, 1);
    chk("t1_state_run", int'(state), 3, 3);

    // ---- 2: stop the toggle in RUN
    wait_win();
    expect_win(0, 0, 1);
    n = 0;
    while (!adc_clk_lost && n < 2 * GATE + 3) begin
      @(negedge clk);
      n++;
    end
    chk("t2_lost", int'(adc_clk_lost), 1, 1);
    chk("t2_adc_rst", int'(adc_rst), 1, 1);
    chk("t2_clk_ok", int'(adc_clk_ok), 0, 0);
    chk("t2_state", int'(state), 0, 0);
    clr_lost = 1'b1;
    @(negedge clk);
    clr_lost = 1'b0;
    chk("t2_clr_lost", int'(adc_clk_lost), 0, 0);

    // ---- 3: too fast, never leaves MEASURE
    tog_per = 3;
    wait_win();
    for (int i = 0; i < 3; i++) begin
      expect_win(3, 33, 34);
      chk("t3_state", int'(state), 0, 0);
      chk("t3_adc_rst", int'(adc_rst), 1, 1);
    end

    // ---- 4: good,good,good,bad then four good -> HOLD only on the 8th
    for (int i = 0; i < 8; i++) begin
      expect_win(pat_per[i], pat_lo[i], pat_hi[i]);
      chk("t4_state", int'(state), pat_st[i], pat_st[i]);
      chk("t4_adc_rst", int'(adc_rst), 1, 1);
    end

    // ---- 5a: restart in HOLD, re-lock after 4 full windows
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("t5_state_restart", int'(state), 0, 0);
    chk("t5_adc_rst", int'(adc_rst), 1, 1);
    for (int i = 0; i < 4; i++) begin
      expect_win(5, 20, 20);
      chk("t5_state", int'(state), (i < 3) ? 1 : 2, (i < 3) ? 1 : 2);
    end
    n = 0;
    while (!adc_clk_ok && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t5_relock_ok", int'(adc_clk_ok), 1, 1);

    // ---- 5b: clr_lost in the same cycle as a bad RUN window end
    wait_win();
    #2;
    tog_per = 0;
    e.lo = 0; e.hi = 1; sb.push_back(e);
    repeat (99) @(negedge clk);
    clr_lost = 1'b1;
    @(negedge clk);
    clr_lost = 1'b0;
    chk("t5_set_beats_clr", int'(adc_clk_lost), 1, 1);
    chk("t5_state_lost", int'(state), 0, 0);

    // ---- window boundary: edge in last gate cycle vs first cycle
    #2;
    e.lo = 1; e.hi = 1; sb.push_back(e);
    repeat (96) @(negedge clk);
    #2 flip_cnt++;                 // edge_p lands in gate cycle 99
    wait_win();
    #2;
    e.lo = 0; e.hi = 0; sb.push_back(e);
    repeat (97) @(negedge clk);
    #2 flip_cnt++;                 // edge_p lands in gate cycle 0 of next window
    wait_win();
    #2;
    e.lo = 1; e.hi = 1; sb.push_back(e);
    wait_win();

    // ---- 6: async reset mid-window in RUN
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    #2 tog_per = 5;
    n = 0;
    while (!adc_clk_ok && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk("t6_run_ok", int'(adc_clk_ok), 1, 1);
    chk("t6_lost_kept", int'(adc_clk_lost), 1, 1);
    repeat (37) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_adc_rst", int'(adc_rst), 1, 1);
    chk("t6_clk_ok", int'(adc_clk_ok), 0, 0);
    chk("t6_lost", int'(adc_clk_lost), 0, 0);
    chk("t6_cnt", int'(adc_cnt), 0, 0);
    chk("t6_valid", int'(cnt_valid), 0, 0);
    chk("t6_state", int'(state), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_drained", sb.size(), 0, 0);
    chk("sb_sat_drained", sb_sat.size(), 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
